// File: rtl/mcyc_ctrl_v2_if.sv
// Control bus between the multi-cycle controller and its datapath.
// master = controller side, slave = datapath side.
interface mcyc_ctrl_v2_if;
    logic [31:0] inst_in;
    logic        zero;
    logic        overflow;
    logic        mio_ready;
    logic        int_req;
    logic        mem_read;
    logic        mem_write;
    logic        cpu_mio;
    logic        iord;
    logic        ir_write;
    logic        reg_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch;
    logic        epc_write;
    logic        int_ack;
    logic [2:0]  alu_op;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic [1:0]  alu_src_a;
    logic [2:0]  alu_src_b;
    logic [2:0]  pc_source;
    logic [4:0]  state_out;
    logic [1:0]  cause;
    logic        err_timeout;

    modport master (
        input  inst_in, zero, overflow, mio_ready, int_req,
        output mem_read, mem_write, cpu_mio, iord, ir_write,
        output reg_write, pc_write, pc_write_cond, branch,
        output epc_write, int_ack, alu_op, reg_dst, mem_to_reg,
        output alu_src_a, alu_src_b, pc_source,
        output state_out, cause, err_timeout
    );

    modport slave (
        output inst_in, zero, overflow, mio_ready, int_req,
        input  mem_read, mem_write, cpu_mio, iord, ir_write,
        input  reg_write, pc_write, pc_write_cond, branch,
        input  epc_write, int_ack, alu_op, reg_dst, mem_to_reg,
        input  alu_src_a, alu_src_b, pc_source,
        input  state_out, cause, err_timeout
    );
endinterface

// File: rtl/mcyc_ctrl_v2.sv
// Multi-cycle MIPS-style control FSM with interrupt/overflow trap
// and memory wait timeout.
module mcyc_ctrl_v2 #(
    parameter int MIO_TIMEOUT = 15,
    parameter int INT_EN      = 1,
    parameter int OVF_TRAP    = 1
) (
    input  logic           clk,
    input  logic           reset,
    mcyc_ctrl_v2_if.master bus
);
    typedef enum logic [4:0] {
        S_IF    = 5'd0,  S_ID    = 5'd1,  S_MEX   = 5'd2,
        S_MRD   = 5'd3,  S_LWB   = 5'd4,  S_MWR   = 5'd5,
        S_REX   = 5'd6,  S_RWB   = 5'd7,  S_IEX   = 5'd8,
        S_IWB   = 5'd9,  S_LUI   = 5'd10, S_BR    = 5'd11,
        S_JAL   = 5'd13, S_JR    = 5'd14, S_J     = 5'd15,
        S_JALR  = 5'd16, S_ERET  = 5'd17, S_TRAP  = 5'd18,
        S_ERR   = 5'd31
    } state_t;

    localparam logic [2:0] ADD = 3'b010;

    state_t      r_state;
    state_t      w_base;
    state_t      w_next;
    logic        r_ie;
    logic [1:0]  r_cause;
    logic [7:0]  r_wait;
    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic        w_hit;
    logic        w_wait_st;
    logic        w_addsub;
    logic        w_ovf_trap;
    logic        w_irq;
    logic        w_unused;

    assign w_op = bus.inst_in[31:26];
    assign w_fn = bus.inst_in[5:0];
    assign w_unused = ^{bus.zero, bus.inst_in[25:6]};
    assign w_hit = ({1'b0, r_wait} + 9'd1) == 9'(MIO_TIMEOUT);
    assign w_wait_st = (r_state == S_IF) || (r_state == S_MRD)
                    || (r_state == S_MWR);

    assign w_addsub =
        ((r_state == S_REX) && (w_op == 6'h00)
            && ((w_fn == 6'h20) || (w_fn == 6'h22)))
        || ((r_state == S_IEX) && (w_op == 6'h08));
    assign w_ovf_trap = (OVF_TRAP != 0) && bus.overflow && w_addsub;

    function automatic logic [2:0] f_ralu(input logic [5:0] fn);
        case (fn)
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h26:   return 3'b011;
            6'h27:   return 3'b100;
            6'h02:   return 3'b101;
            6'h22:   return 3'b110;
            6'h2a:   return 3'b111;
            default: return ADD;
        endcase
    endfunction

    function automatic logic [2:0] f_ialu(input logic [5:0] op);
        case (op)
            6'h0c:   return 3'b000;
            6'h0d:   return 3'b001;
            6'h0e:   return 3'b011;
            6'h0a:   return 3'b111;
            default: return ADD;
        endcase
    endfunction

    always_comb begin
        w_base = S_IF;
        case (r_state)
            S_IF:  w_base = bus.mio_ready ? S_ID
                          : (w_hit ? S_ERR : S_IF);
            S_ID: begin
                if (w_op == 6'h00) begin
                    case (w_fn)
                        6'h20, 6'h22, 6'h24, 6'h25,
                        6'h26, 6'h27, 6'h2a, 6'h02: w_base = S_REX;
                        6'h08:   w_base = S_JR;
                        6'h09:   w_base = S_JALR;
                        default: w_base = S_IF;
                    endcase
                end else begin
                    case (w_op)
                        6'h23, 6'h2b: w_base = S_MEX;
                        6'h08, 6'h0c, 6'h0d,
                        6'h0e, 6'h0a: w_base = S_IEX;
                        6'h0f:        w_base = S_LUI;
                        6'h04, 6'h05: w_base = S_BR;
                        6'h02:        w_base = S_J;
                        6'h03:        w_base = S_JAL;
                        6'h10: w_base = (w_fn == 6'h18) ? S_ERET : S_IF;
                        default:      w_base = S_IF;
                    endcase
                end
            end
            S_MEX: w_base = (w_op == 6'h23) ? S_MRD : S_MWR;
            S_MRD: w_base = bus.mio_ready ? S_LWB
                          : (w_hit ? S_ERR : S_MRD);
            S_MWR: w_base = bus.mio_ready ? S_IF
                          : (w_hit ? S_ERR : S_MWR);
            S_REX: w_base = w_ovf_trap ? S_TRAP : S_RWB;
            S_IEX: w_base = w_ovf_trap ? S_TRAP : S_IWB;
            S_ERR: w_base = S_ERR;
            default: w_base = S_IF;
        endcase
    end

    // IF self-loop is a wait, not a return to IF; TRAP itself never re-traps
    assign w_irq = (INT_EN != 0) && r_ie && bus.int_req
                && (w_base == S_IF) && (r_state != S_IF)
                && (r_state != S_TRAP);
    assign w_next = w_irq ? S_TRAP : w_base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IF;
            r_ie    <= 1'b1;
            r_cause <= 2'b00;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP) begin
                r_ie    <= 1'b0;
                r_cause <= w_ovf_trap ? 2'b10 : 2'b01;
            end else if (r_state == S_ERET) begin
                r_ie <= 1'b1;
            end
            if (w_wait_st && !bus.mio_ready && (w_next == r_state))
                r_wait <= r_wait + 8'd1;
            else
                r_wait <= 8'd0;
        end
    end

    assign bus.state_out = r_state;
    assign bus.cause     = r_cause;

    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.cpu_mio       = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch        = 1'b0;
        bus.epc_write     = 1'b0;
        bus.int_ack       = 1'b0;
        bus.alu_op        = 3'b000;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 3'b000;
        bus.pc_source     = 3'b000;
        bus.err_timeout   = 1'b0;
        case (r_state)
            S_IF: begin
                bus.mem_read  = 1'b1;
                bus.cpu_mio   = 1'b1;
                bus.ir_write  = 1'b1;
                bus.pc_write  = 1'b1;
                bus.alu_src_b = 3'b001;
                bus.alu_op    = ADD;
            end
            S_ID: begin
                bus.alu_src_b = 3'b100;
                bus.alu_op    = ADD;
            end
            S_REX: begin
                bus.alu_src_a = 2'b01;
                bus.alu_op    = f_ralu(w_fn);
                if (w_fn == 6'h02) begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 3'b010;
                end
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b01;
            end
            S_IEX: begin
                bus.alu_src_a = 2'b01;
                bus.alu_op    = f_ialu(w_op);
                bus.alu_src_b = ((w_op == 6'h08) || (w_op == 6'h0a))
                              ? 3'b010 : 3'b011;
            end
            S_IWB: bus.reg_write = 1'b1;
            S_MEX: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 3'b010;
                bus.alu_op    = ADD;
            end
            S_MRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                bus.cpu_mio  = 1'b1;
            end
            S_LWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
            end
            S_MWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                bus.cpu_mio   = 1'b1;
            end
            S_BR: begin
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 3'b001;
                bus.alu_op        = 3'b110;
                bus.alu_src_a     = 2'b01;
                bus.branch        = (w_op == 6'h04);
            end
            S_J: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 3'b010;
            end
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 3'b010;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b10;
                bus.mem_to_reg = 2'b11;
            end
            S_JR: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 3'b011;
            end
            S_JALR: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = 3'b011;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b01;
                bus.mem_to_reg = 2'b11;
            end
            S_LUI: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b10;
            end
            S_ERET: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 3'b101;
            end
            S_TRAP: begin
                bus.epc_write = 1'b1;
                bus.pc_write  = 1'b1;
                bus.pc_source = 3'b100;
                bus.int_ack   = 1'b1;
            end
            S_ERR: bus.err_timeout = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mcyc_ctrl_v2.sv
// Bench for mcyc_ctrl_v2: instruction-level reference model predicting
// the state path, strobes, cause and timeout behaviour.
module tb_mcyc_ctrl_v2;
    localparam int TO = 15;
    localparam int S_IF = 0, S_ID = 1, S_MEX = 2, S_MRD = 3, S_LWB = 4;
    localparam int S_MWR = 5, S_REX = 6, S_RWB = 7, S_IEX = 8, S_IWB = 9;
    localparam int S_LUI = 10, S_BR = 11, S_JAL = 13, S_JR = 14, S_J = 15;
    localparam int S_JALR = 16, S_ERET = 17, S_TRAP = 18, S_ERR = 31;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    bit   m_ie;
    logic [1:0] m_cause;

    mcyc_ctrl_v2_if bus();

    mcyc_ctrl_v2 #(
        .MIO_TIMEOUT(TO),
        .INT_EN(1),
        .OVF_TRAP(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] got_ctl();
        return {bus.mem_read, bus.mem_write, bus.cpu_mio, bus.iord,
                bus.ir_write, bus.reg_write, bus.pc_write,
                bus.pc_write_cond, bus.branch, bus.epc_write,
                bus.int_ack, bus.alu_op, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                bus.err_timeout};
    endfunction

    function automatic logic [2:0] r_alu(logic [5:0] fn);
        case (fn)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h26: return 3'b011;
            6'h27: return 3'b100;
            6'h2a: return 3'b111;
            6'h02: return 3'b101;
            default: return 3'bxxx;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(logic [5:0] op);
        case (op)
            6'h08: return 3'b010;
            6'h0c: return 3'b000;
            6'h0d: return 3'b001;
            6'h0e: return 3'b011;
            6'h0a: return 3'b111;
            default: return 3'bxxx;
        endcase
    endfunction

    // Expected strobes per state, from the controller's datasheet table
    function automatic logic [26:0] exp_ctl(int s, logic [31:0] ir);
        logic [5:0] op = ir[31:26];
        logic [5:0] fn = ir[5:0];
        logic mr = 0, mw = 0, mio = 0, io = 0, irw = 0, rw = 0;
        logic pcw = 0, pcc = 0, br = 0, epc = 0, ack = 0, err = 0;
        logic [2:0] aop = 0, asb = 0, pcs = 0;
        logic [1:0] rd = 0, m2r = 0, asa = 0;
        case (s)
            S_IF: begin
                mr = 1; mio = 1; irw = 1; pcw = 1;
                asb = 3'b001; aop = 3'b010;
            end
            S_ID:  begin asb = 3'b100; aop = 3'b010; end
            S_REX: begin
                aop = r_alu(fn);
                if (fn == 6'h02) begin asa = 2'b10; asb = 3'b010; end
                else asa = 2'b01;
            end
            S_RWB: begin rw = 1; rd = 2'b01; end
            S_IEX: begin
                asa = 2'b01; aop = i_alu(op);
                asb = (op == 6'h08 || op == 6'h0a) ? 3'b010 : 3'b011;
            end
            S_IWB: rw = 1;
            S_MEX: begin asa = 2'b01; asb = 3'b010; aop = 3'b010; end
            S_MRD: begin mr = 1; io = 1; mio = 1; end
            S_LWB: begin rw = 1; m2r = 2'b01; end
            S_MWR: begin mw = 1; io = 1; mio = 1; end
            S_BR: begin
                pcc = 1; pcs = 3'b001; aop = 3'b110; asa = 2'b01;
                br = (op == 6'h04);
            end
            S_J:   begin pcw = 1; pcs = 3'b010; end
            S_JAL: begin
                pcw = 1; pcs = 3'b010; rw = 1; rd = 2'b10; m2r = 2'b11;
            end
            S_JR:  begin pcw = 1; pcs = 3'b011; end
            S_JALR: begin
                pcw = 1; pcs = 3'b011; rw = 1; rd = 2'b01; m2r = 2'b11;
            end
            S_LUI:  begin rw = 1; m2r = 2'b10; end
            S_ERET: begin pcw = 1; pcs = 3'b101; end
            S_TRAP: begin epc = 1; pcw = 1; pcs = 3'b100; ack = 1; end
            S_ERR:  err = 1;
            default: ;
        endcase
        return {mr, mw, mio, io, irw, rw, pcw, pcc, br, epc, ack,
                aop, rd, m2r, asa, asb, pcs, err};
    endfunction

    task automatic check_now(int s, logic [31:0] ir, string tag);
        chk({tag, "/state"}, 32'(bus.state_out), 32'(s));
        chk({tag, "/ctl"}, 32'(got_ctl()), 32'(exp_ctl(s, ir)));
    endtask

    // Runs one instruction from IF; ifw/mw = mio_ready-low cycles
    task automatic do_instr(string tag, logic [31:0] ir, int ifw,
                            int mw, bit ovf, bit irq);
        int q[$];
        logic [5:0] op = ir[31:26];
        logic [5:0] fn = ir[5:0];
        bit ovt = 0;
        bit eret = 0;
        bit rdy;
        for (int i = 0; i <= ifw; i++) q.push_back(S_IF);
        q.push_back(S_ID);
        if (op == 0 && fn inside {6'h20, 6'h22, 6'h24, 6'h25,
                                  6'h26, 6'h27, 6'h2a, 6'h02}) begin
            q.push_back(S_REX);
            if (ovf && fn inside {6'h20, 6'h22}) ovt = 1;
            else q.push_back(S_RWB);
        end else if (op == 0 && fn == 6'h08) q.push_back(S_JR);
        else if (op == 0 && fn == 6'h09) q.push_back(S_JALR);
        else if (op == 6'h23 || op == 6'h2b) begin
            q.push_back(S_MEX);
            for (int i = 0; i <= mw; i++)
                q.push_back(op == 6'h23 ? S_MRD : S_MWR);
            if (op == 6'h23) q.push_back(S_LWB);
        end else if (op inside {6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a}) begin
            q.push_back(S_IEX);
            if (ovf && op == 6'h08) ovt = 1;
            else q.push_back(S_IWB);
        end else if (op == 6'h0f) q.push_back(S_LUI);
        else if (op == 6'h04 || op == 6'h05) q.push_back(S_BR);
        else if (op == 6'h02) q.push_back(S_J);
        else if (op == 6'h03) q.push_back(S_JAL);
        else if (op == 6'h10 && fn == 6'h18) begin
            q.push_back(S_ERET);
            eret = 1;
        end
        if (ovt || (irq && m_ie)) q.push_back(S_TRAP);

        bus.inst_in  = ir;
        bus.overflow = ovf;
        bus.int_req  = irq;
        foreach (q[k]) begin
            if (q[k] inside {S_IF, S_MRD, S_MWR})
                rdy = (k + 1 == q.size()) || (q[k+1] != q[k]);
            else
                rdy = 1'($urandom);
            bus.mio_ready = rdy;
            bus.zero = 1'($urandom);
            check_now(q[k], ir, $sformatf("%s[%0d]", tag, k));
            @(posedge clk); #1;
        end

        if (ovt) begin
            m_cause = 2'b10;
            m_ie = 0;
        end else if (irq && m_ie) begin
            m_cause = 2'b01;
            m_ie = 0;
        end else if (eret) begin
            m_ie = 1;
        end
        chk({tag, "/cause"}, 32'(bus.cause), 32'(m_cause));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] ir = $urandom;
        logic [5:0] rf [0:9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h2a, 6'h02, 6'h08, 6'h09};
        logic [5:0] io [0:4] = '{6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a};
        logic [5:0] ot [0:6] = '{6'h23, 6'h2b, 6'h0f, 6'h04,
                                 6'h05, 6'h02, 6'h03};
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                ir[31:26] = 6'h00;
                ir[5:0] = rf[$urandom_range(0, 9)];
            end
            3, 4: ir[31:26] = io[$urandom_range(0, 4)];
            5, 6, 7: ir[31:26] = ot[$urandom_range(0, 6)];
            8: begin ir[31:26] = 6'h10; ir[5:0] = 6'h18; end
            default: begin
                if ($urandom_range(0, 1) == 1) ir[31:26] = 6'h3f;
                else begin ir[31:26] = 6'h00; ir[5:0] = 6'h3f; end
            end
        endcase
        return ir;
    endfunction

    localparam logic [31:0] ADD_I  = {6'h00, 20'h4a5c3, 6'h20};
    localparam logic [31:0] LW_I   = {6'h23, 26'h0a40010};
    localparam logic [31:0] SW_I   = {6'h2b, 26'h0a40014};
    localparam logic [31:0] ERET_I = {6'h10, 20'h80000, 6'h18};
    localparam logic [31:0] BEQ_I  = {6'h04, 26'h0220003};
    localparam logic [31:0] BNE_I  = {6'h05, 26'h0220003};
    localparam logic [31:0] BAD_I  = {6'h3f, 26'h1234567};

    initial begin
        reset = 1'b1;
        bus.inst_in   = 32'd0;
        bus.zero      = 1'b0;
        bus.overflow  = 1'b0;
        bus.mio_ready = 1'b0;
        bus.int_req   = 1'b0;
        m_ie = 1;
        m_cause = 2'b00;
        #12;
        check_now(S_IF, 32'd0, "reset_held");
        chk("reset_cause", 32'(bus.cause), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_instr("add", ADD_I, 0, 0, 0, 0);
        do_instr("lw_wait3", LW_I, 0, 3, 0, 0);
        do_instr("add_ovf", ADD_I, 1, 0, 1, 0);
        do_instr("eret1", ERET_I, 0, 0, 0, 0);
        do_instr("add_irq", ADD_I, 0, 0, 0, 1);
        do_instr("irq_masked", ADD_I, 0, 0, 0, 1);
        do_instr("eret_irq", ERET_I, 0, 0, 0, 1);
        do_instr("irq_taken", ADD_I, 0, 0, 0, 1);
        do_instr("beq", BEQ_I, 0, 0, 0, 0);
        do_instr("bne", BNE_I, 0, 0, 0, 0);
        do_instr("undef", BAD_I, 2, 0, 0, 0);
        do_instr("if_wait14", ADD_I, TO - 1, 0, 0, 0);
        do_instr("sw_wait14", SW_I, 0, TO - 1, 0, 0);

        // async reset in the middle of a store
        bus.inst_in = SW_I;
        bus.int_req = 1'b0;
        bus.mio_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.mio_ready = 1'b0;
        check_now(S_MWR, SW_I, "pre_reset_mwr");
        #2 reset = 1'b1;
        #1 check_now(S_IF, SW_I, "async_reset");
        chk("async_reset_cause", 32'(bus.cause), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_ie = 1;
        m_cause = 2'b00;

        for (int n = 0; n < 80; n++)
            do_instr($sformatf("rnd%0d", n), rand_inst(),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0);

        bus.mio_ready = 1'b0;
        bus.int_req = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            @(posedge clk); #1;
            chk($sformatf("timeout_%0d", i), 32'(bus.state_out),
                32'(i < TO ? S_IF : S_ERR));
        end
        bus.mio_ready = 1'b1;
        bus.int_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check_now(S_ERR, bus.inst_in, "err_hold");
        #2 reset = 1'b1;
        #1 check_now(S_IF, bus.inst_in, "err_reset");
        @(negedge clk);
        reset = 1'b0;
        m_ie = 1;
        m_cause = 2'b00;
        do_instr("post_err", ADD_I, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
